mw_writeback: RTL and testbench

- Stage-3 memory/writeback register of the 3-stage RV32 pipeline.
- Captures execute-stage results and waits on the data-cache load response when needed.
- Aligns and extends load data, then drives the register-file write port.
- Publishes the rd_mw / rwe_mw / wb_data_mw triple that the stage-2 operand-forwarding logic consumes, so it is the producer end of that forwarding interface.

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/load_align.sv | 29 ++
 rtl/mw_writeback.sv | 103 ++++++++++
 tb/tb_mw_writeback.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32 pipeline: writeback source select, load funct3
// codes and the memory/writeback stage FSM states.
package riscv_pkg;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  typedef enum logic {
    MW_RUN      = 1'b0,
    MW_WAIT_MEM = 1'b1
  } mw_state_e;

endpackage

// File: rtl/load_align.sv
// Extracts and extends the addressed byte/halfword of a word-aligned load.
// Misaligned halfword offsets are not trapped; off[0] is ignored for halves.
module load_align
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{off, 3'b000} +: 8];
    half_sel = word[{off[1], 4'b0000} +: 16];
    case (funct3)
      FUNCT3_LB:  value = {{(XLEN - 8){byte_sel[7]}}, byte_sel};
      FUNCT3_LH:  value = {{(XLEN - 16){half_sel[15]}}, half_sel};
      FUNCT3_LBU: value = {{(XLEN - 8){1'b0}}, byte_sel};
      FUNCT3_LHU: value = {{(XLEN - 16){1'b0}}, half_sel};
      default:    value = word;
    endcase
  end

endmodule

// File: rtl/mw_writeback.sv
// Stage-3 memory/writeback register: holds the executed instruction, waits for
// the load response when needed and drives the register-file write port.
module mw_writeback
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_x,
  input  logic [REG_AW-1:0] rd_x,
  input  logic              rwe_x,
  input  logic [1:0]        wb_sel_x,
  input  logic [2:0]        funct3_x,
  input  logic [XLEN-1:0]   alu_x,
  input  logic [XLEN-1:0]   pc4_x,
  input  logic              dmem_resp_valid,
  input  logic [XLEN-1:0]   dmem_resp_data,
  output logic              stall,
  output logic [REG_AW-1:0] rd_mw,
  output logic              rwe_mw,
  output logic [XLEN-1:0]   wb_data_mw,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata
);

  mw_state_e         state_q;
  logic              valid_q;
  logic [REG_AW-1:0] rd_q;
  logic              rwe_q;
  logic [1:0]        wb_sel_q;
  logic [2:0]        funct3_q;
  logic [XLEN-1:0]   alu_q;
  logic [XLEN-1:0]   pc4_q;
  logic [XLEN-1:0]   mem_data_q;
  logic [XLEN-1:0]   load_value;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= MW_RUN;
      valid_q    <= 1'b0;
      rd_q       <= '0;
      rwe_q      <= 1'b0;
      wb_sel_q   <= '0;
      funct3_q   <= '0;
      alu_q      <= '0;
      pc4_q      <= '0;
      mem_data_q <= '0;
    end else begin
      case (state_q)
        MW_RUN: begin
          valid_q  <= valid_x;
          rd_q     <= rd_x;
          rwe_q    <= rwe_x;
          wb_sel_q <= wb_sel_x;
          funct3_q <= funct3_x;
          alu_q    <= alu_x;
          pc4_q    <= pc4_x;
          if (valid_x && (wb_sel_x == WB_MEM)) begin
            state_q <= MW_WAIT_MEM;
          end
        end
        MW_WAIT_MEM: begin
          // Instruction fields stay frozen; only the load data is captured here.
          if (dmem_resp_valid) begin
            mem_data_q <= dmem_resp_data;
            state_q    <= MW_RUN;
          end
        end
        default: state_q <= MW_RUN;
      endcase
    end
  end

  assign stall = (state_q == MW_WAIT_MEM);

  load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .funct3(funct3_q),
    .off   (alu_q[1:0]),
    .word  (mem_data_q),
    .value (load_value)
  );

  always_comb begin
    case (wb_sel_q)
      WB_MEM:  wb_data_mw = load_value;
      WB_PC4:  wb_data_mw = pc4_q;
      default: wb_data_mw = alu_q;
    endcase
  end

  // x0 is never advertised to forwarding nor written.
  assign rwe_mw   = valid_q & rwe_q & (rd_q != '0);
  assign rd_mw    = rd_q;
  assign rf_we    = rwe_mw & ~stall;
  assign rf_waddr = rd_mw;
  assign rf_wdata = wb_data_mw;

endmodule

// File: tb/tb_mw_writeback.sv
// Self-checking bench for mw_writeback: scenario tasks plus a write scoreboard
// that matches every register-file write against the expected queue.
module tb_mw_writeback;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_x;
  logic [4:0]  rd_x;
  logic        rwe_x;
  logic [1:0]  wb_sel_x;
  logic [2:0]  funct3_x;
  logic [31:0] alu_x;
  logic [31:0] pc4_x;
  logic        dmem_resp_valid;
  logic [31:0] dmem_resp_data;
  logic        stall;
  logic [4:0]  rd_mw;
  logic        rwe_mw;
  logic [31:0] wb_data_mw;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t sb_e;
  int  passed = 0;
  int  total  = 0;

  mw_writeback dut (
    .clk            (clk),
    .reset          (reset),
    .valid_x        (valid_x),
    .rd_x           (rd_x),
    .rwe_x          (rwe_x),
    .wb_sel_x       (wb_sel_x),
    .funct3_x       (funct3_x),
    .alu_x          (alu_x),
    .pc4_x          (pc4_x),
    .dmem_resp_valid(dmem_resp_valid),
    .dmem_resp_data (dmem_resp_data),
    .stall          (stall),
    .rd_mw          (rd_mw),
    .rwe_mw         (rwe_mw),
    .wb_data_mw     (wb_data_mw),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata)
  );

  always #5 clk = ~clk;

  // Scoreboard: every write the DUT commits must match the oldest expectation.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected_write: got x%0d=%h, required no write", rf_waddr, rf_wdata);
      end else begin
        sb_e = exp_q.pop_front();
        if (rf_waddr !== sb_e.addr || rf_wdata !== sb_e.data)
          $display("FAIL sb_write: got x%0d=%h, required x%0d=%h",
                   rf_waddr, rf_wdata, sb_e.addr, sb_e.data);
        else passed++;
      end
    end
  end

  task automatic drive_x(input logic v, input logic [4:0] rd, input logic we,
                         input logic [1:0] sel, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] pc4);
    valid_x  = v;
    rd_x     = rd;
    rwe_x    = we;
    wb_sel_x = sel;
    funct3_x = f3;
    alu_x    = alu;
    pc4_x    = pc4;
  endtask

  task automatic test_reset();
    reset           = 1'b1;
    dmem_resp_valid = 1'b0;
    dmem_resp_data  = '0;
    drive_x(1'b0, 5'd0, 1'b0, 2'd0, 3'd0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({stall, rwe_mw, rf_we, rd_mw, wb_data_mw} !== 40'h0)
      $display("FAIL reset_state: got stall=%b rwe=%b we=%b rd=%0d wb=%h, required all 0",
               stall, rwe_mw, rf_we, rd_mw, wb_data_mw);
    else passed++;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({stall, rwe_mw, rf_we} !== 3'b000)
      $display("FAIL reset_idle: got stall=%b rwe=%b we=%b, required 000", stall, rwe_mw, rf_we);
    else passed++;
  endtask

  // Non-load instructions issued back to back; each writes the cycle after capture.
  task automatic test_alu_paths();
    logic [1:0]  sel [6] = '{2'd0, 2'd0, 2'd2, 2'd3, 2'd0, 2'd2};
    logic [4:0]  rd  [6] = '{5'd5, 5'd0, 5'd9, 5'd10, 5'd6, 5'd31};
    logic        we  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] alu [6] = '{32'h1234, 32'hFFFF, 32'hAAAA, 32'h55, 32'h77, 32'h1};
    logic [31:0] pc4 [6] = '{32'h4, 32'h8, 32'h100, 32'h200, 32'h300, 32'hFFFF_FFFC};
    logic [31:0] expd;
    logic        expw;
    for (int i = 0; i < 6; i++) begin
      expd = (sel[i] == 2'd2) ? pc4[i] : alu[i];
      expw = we[i] && (rd[i] != 5'd0);
      drive_x(1'b1, rd[i], we[i], sel[i], 3'd0, alu[i], pc4[i]);
      if (expw) exp_q.push_back('{rd[i], expd});
      @(posedge clk);
      #1;
      @(negedge clk);
      total++;
      if ({stall, rwe_mw, rf_we, rd_mw, wb_data_mw} !== {1'b0, expw, expw, rd[i], expd})
        $display("FAIL alu_path[%0d]: got stall=%b rwe=%b we=%b rd=%0d wb=%h, required 0 %b %b %0d %h",
                 i, stall, rwe_mw, rf_we, rd_mw, wb_data_mw, expw, expw, rd[i], expd);
      else passed++;
    end
    drive_x(1'b0, 5'd12, 1'b1, 2'd0, 3'd0, 32'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({rwe_mw, rf_we} !== 2'b00)
      $display("FAIL alu_bubble: got rwe=%b we=%b, required 00", rwe_mw, rf_we);
    else passed++;
  endtask

  task automatic test_load(input string name, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] data,
                           input int lat, input logic [31:0] expv);
    drive_x(1'b1, rd, 1'b1, WB_MEM, f3, addr, 32'h0);
    if (rd != 5'd0) exp_q.push_back('{rd, expv});
    @(posedge clk);
    #1;
    drive_x(1'b0, 5'd0, 1'b0, 2'd0, 3'd0, 32'h0, 32'h0);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      total++;
      if ({stall, rf_we} !== 2'b10)
        $display("FAIL %s_wait[%0d]: got stall=%b we=%b, required 10", name, i, stall, rf_we);
      else passed++;
      if (i == lat - 1) begin
        dmem_resp_valid = 1'b1;
        dmem_resp_data  = data;
      end
    end
    @(posedge clk);
    #1;
    dmem_resp_valid = 1'b0;
    dmem_resp_data  = '0;
    @(negedge clk);
    total++;
    if ({stall, rf_we, rf_waddr, rf_wdata} !== {1'b0, rd != 5'd0, rd, expv})
      $display("FAIL %s_done: got stall=%b we=%b x%0d=%h, required 0 %b x%0d=%h",
               name, stall, rf_we, rf_waddr, rf_wdata, rd != 5'd0, rd, expv);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic exp_stall [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    drive_x(1'b1, 5'd3, 1'b1, WB_MEM, FUNCT3_LW, 32'h10, 32'h0);
    exp_q.push_back('{5'd3, 32'hCAFE_BABE});
    exp_q.push_back('{5'd4, 32'h0000_00AB});
    @(posedge clk);
    #1;
    // Second load sits on the X inputs, held while the first one waits.
    drive_x(1'b1, 5'd4, 1'b1, WB_MEM, FUNCT3_LBU, 32'h21, 32'h0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if (stall !== exp_stall[c])
        $display("FAIL b2b_stall[%0d]: got %b, required %b", c, stall, exp_stall[c]);
      else passed++;
      if (c == 1 || c == 4) begin
        dmem_resp_valid = 1'b1;
        dmem_resp_data  = (c == 1) ? 32'hCAFE_BABE : 32'h0000_AB00;
      end
      @(posedge clk);
      #1;
      dmem_resp_valid = 1'b0;
      dmem_resp_data  = '0;
      if (c == 2) drive_x(1'b0, 5'd0, 1'b0, 2'd0, 3'd0, 32'h0, 32'h0);
    end
  endtask

  task automatic test_resp_in_run();
    @(negedge clk);
    dmem_resp_valid = 1'b1;
    dmem_resp_data  = 32'h1111_2222;
    @(posedge clk);
    #1;
    dmem_resp_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({stall, rf_we} !== 2'b00)
      $display("FAIL resp_in_run: got stall=%b we=%b, required 00", stall, rf_we);
    else passed++;
  endtask

  task automatic test_reset_in_wait();
    drive_x(1'b1, 5'd6, 1'b1, WB_MEM, FUNCT3_LW, 32'h40, 32'h0);
    @(posedge clk);
    #1;
    drive_x(1'b0, 5'd0, 1'b0, 2'd0, 3'd0, 32'h0, 32'h0);
    @(negedge clk);
    total++;
    if (stall !== 1'b1)
      $display("FAIL rst_wait_pre: got stall=%b, required 1", stall);
    else passed++;
    reset           = 1'b1;
    dmem_resp_valid = 1'b1;
    dmem_resp_data  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    reset           = 1'b0;
    dmem_resp_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({stall, rwe_mw, rf_we, wb_data_mw} !== {3'b000, 32'h0})
      $display("FAIL rst_wait_post: got stall=%b rwe=%b we=%b wb=%h, required 000 00000000",
               stall, rwe_mw, rf_we, wb_data_mw);
    else passed++;
    @(negedge clk);
    total++;
    if ({stall, rf_we} !== 2'b00)
      $display("FAIL rst_wait_settle: got stall=%b we=%b, required 00", stall, rf_we);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_alu_paths();
    test_load("lb_sign",  5'd7,  FUNCT3_LB,  32'h0000_1002, 32'h0080_0000, 3, 32'hFFFF_FF80);
    test_load("lhu_zero", 5'd8,  FUNCT3_LHU, 32'h0000_2002, 32'h8001_ABCD, 2, 32'h0000_8001);
    test_load("lh_sign",  5'd11, FUNCT3_LH,  32'h0000_2000, 32'h8001_ABCD, 1, 32'hFFFF_ABCD);
    test_load("lb_off1",  5'd12, FUNCT3_LB,  32'h0000_0001, 32'h0000_FF00, 2, 32'hFFFF_FFFF);
    test_load("lbu_off3", 5'd13, FUNCT3_LBU, 32'h0000_0003, 32'hF700_0000, 1, 32'h0000_00F7);
    test_load("lw",       5'd14, FUNCT3_LW,  32'h0000_0008, 32'h1357_9BDF, 4, 32'h1357_9BDF);
    test_load("lh_mis",   5'd15, FUNCT3_LH,  32'h0000_0003, 32'h1234_8765, 1, 32'h0000_1234);
    test_load("f3_other", 5'd16, 3'b011,     32'h0000_0001, 32'hA5A5_0F0F, 1, 32'hA5A5_0F0F);
    test_load("load_x0",  5'd0,  FUNCT3_LW,  32'h0000_0004, 32'h7777_7777, 2, 32'h7777_7777);
    test_back_to_back();
    test_resp_in_run();
    test_reset_in_wait();
    repeat (2) @(negedge clk);
    total++;
    if (exp_q.size() != 0)
      $display("FAIL sb_drain: got %0d pending writes, required 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
